// File: rtl/gemm_stream_engine.sv
// gemm_stream_engine: runtime-sized streaming GEMM.
// Computes C' = (alpha*(A*op(B)) + beta*C) >>> FRAC_BITS one element at a time
// and hands each result out over a valid/ready handshake in row-major order.
module gemm_stream_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int DIM_MAX    = 8,
    parameter int FRAC_BITS  = 8
) (
    input  logic                                iclk,
    input  logic                                irst,
    input  logic                                istart,
    input  logic        [$clog2(DIM_MAX):0]     idim_m,
    input  logic        [$clog2(DIM_MAX):0]     idim_n,
    input  logic        [$clog2(DIM_MAX):0]     idim_k,
    input  logic                                itrans_b,
    input  logic                                isat,
    input  logic signed [DATA_WIDTH-1:0]        ialpha,
    input  logic signed [DATA_WIDTH-1:0]        ibeta,
    input  logic signed [DATA_WIDTH-1:0]        ia_matrix [DIM_MAX][DIM_MAX],
    input  logic signed [DATA_WIDTH-1:0]        ib_matrix [DIM_MAX][DIM_MAX],
    input  logic signed [DATA_WIDTH-1:0]        ic_matrix [DIM_MAX][DIM_MAX],
    input  logic                                iready,
    output logic                                ovalid,
    output logic signed [DATA_WIDTH-1:0]        odata,
    output logic        [$clog2(DIM_MAX)-1:0]   orow,
    output logic        [$clog2(DIM_MAX)-1:0]   ocol,
    output logic                                obusy,
    output logic                                odone,
    output logic                                oerr
);

    localparam int DW = $clog2(DIM_MAX) + 1;          // dimension width
    localparam int IW = $clog2(DIM_MAX);              // index width
    localparam int PW = 2 * DATA_WIDTH;               // full product width
    localparam int TW = DATA_WIDTH + ACC_WIDTH + 1;   // scaling width
    localparam logic [DW-1:0] ONE = DW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_SCALE,
        S_OUT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic        [DW-1:0]         dim_m_q, dim_n_q, dim_k_q;
    logic                         trans_q, sat_q, err_q;
    logic signed [DATA_WIDTH-1:0] alpha_q, beta_q;
    logic        [IW-1:0]         i_q, j_q, k_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [DATA_WIDTH-1:0] data_q;
    logic        [IW-1:0]         row_q, col_q;

    logic                         start_bad;
    logic                         k_last, i_last, j_last;
    logic signed [DATA_WIDTH-1:0] a_op, b_op;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;

    // A dimension is unusable when zero or larger than the operand arrays.
    function automatic logic dim_bad(input logic [DW-1:0] d);
        return (d == '0) || (d > DW'(DIM_MAX));
    endfunction

    // Clamp to the DATA_WIDTH signed range, or keep the low bits (wrap).
    function automatic logic signed [DATA_WIDTH-1:0] saturate(
        input logic signed [TW-1:0] r,
        input logic                 sat_en
    );
        logic signed [TW-1:0] sat_max, sat_min;
        sat_max = {{(TW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        sat_min = {{(TW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
        if (sat_en && (r > sat_max)) return sat_max[DATA_WIDTH-1:0];
        if (sat_en && (r < sat_min)) return sat_min[DATA_WIDTH-1:0];
        return r[DATA_WIDTH-1:0];
    endfunction

    // Scale accumulator and C term, then floor-shift out the fraction bits.
    function automatic logic signed [DATA_WIDTH-1:0] scale_result(
        input logic signed [ACC_WIDTH-1:0]  acc,
        input logic signed [DATA_WIDTH-1:0] alpha,
        input logic signed [DATA_WIDTH-1:0] beta,
        input logic signed [DATA_WIDTH-1:0] c,
        input logic                         sat_en
    );
        logic signed [TW-1:0] alpha_x, beta_x, acc_x, c_x, t;
        alpha_x = TW'(alpha);
        beta_x  = TW'(beta);
        acc_x   = TW'(acc);
        c_x     = TW'(c);
        t       = alpha_x * acc_x + beta_x * c_x;
        return saturate(t >>> FRAC_BITS, sat_en);
    endfunction

    assign start_bad = dim_bad(idim_m) || dim_bad(idim_n) || dim_bad(idim_k);
    assign k_last    = ({1'b0, k_q} == dim_k_q - ONE);
    assign i_last    = ({1'b0, i_q} == dim_m_q - ONE);
    assign j_last    = ({1'b0, j_q} == dim_n_q - ONE);

    // Select the current operand pair and form the sign-extended product.
    always_comb begin
        a_op     = ia_matrix[i_q][k_q];
        b_op     = trans_q ? ib_matrix[j_q][k_q] : ib_matrix[k_q][j_q];
        prod     = a_op * b_op;
        prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    end

    // State register.
    always_ff @(posedge iclk) begin
        if (irst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_d = state_q;
        ovalid  = 1'b0;
        obusy   = 1'b0;
        odone   = 1'b0;
        oerr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (istart) state_d = start_bad ? S_DONE : S_MAC;
            end
            S_MAC: begin
                obusy = 1'b1;
                if (k_last) state_d = S_SCALE;
            end
            S_SCALE: begin
                obusy   = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                obusy  = 1'b1;
                ovalid = 1'b1;
                if (iready) state_d = (i_last && j_last) ? S_DONE : S_MAC;
            end
            S_DONE: begin
                odone   = 1'b1;
                oerr    = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Job capture, index walk, accumulation and result register.
    always_ff @(posedge iclk) begin
        if (irst) begin
            dim_m_q <= '0;
            dim_n_q <= '0;
            dim_k_q <= '0;
            trans_q <= 1'b0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            alpha_q <= '0;
            beta_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (istart) begin
                        dim_m_q <= idim_m;
                        dim_n_q <= idim_n;
                        dim_k_q <= idim_k;
                        trans_q <= itrans_b;
                        sat_q   <= isat;
                        alpha_q <= ialpha;
                        beta_q  <= ibeta;
                        err_q   <= start_bad;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        acc_q   <= '0;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_q + prod_ext;
                    k_q   <= k_q + 1'b1;
                end
                S_SCALE: begin
                    data_q <= scale_result(acc_q, alpha_q, beta_q,
                                           ic_matrix[i_q][j_q], sat_q);
                    row_q  <= i_q;
                    col_q  <= j_q;
                end
                S_OUT: begin
                    if (iready && !(i_last && j_last)) begin
                        k_q   <= '0;
                        acc_q <= '0;
                        if (j_last) begin
                            j_q <= '0;
                            i_q <= i_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign odata = data_q;
    assign orow  = row_q;
    assign ocol  = col_q;

endmodule
